// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs a single-outstanding req/ack handshake with
// instruction memory, and buffers fetched words with their PCs in a circular queue.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     rclk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [1:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enq, deq, has_space, new_req;
  logic [31:0]     target_pc;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // Queue bookkeeping and fetch PC; redirect overrides any same-cycle enq/deq.
  always_comb begin
    enq        = (state_q == S_FETCH) && imem_ack && !redirect;
    deq        = (count_q != '0) && inst_ready && !redirect;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = target_pc;
    end else begin
      if (enq) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
    has_space = count_d < CW'(DEPTH);
  end

  // Next-state logic; a request already issued is only ever retired by its ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (has_space) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (!redirect && !has_space) state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    new_req = (state_d == S_FETCH) && ((state_q != S_FETCH) || imem_ack);
    req_d   = (state_d == S_FETCH) || (state_d == S_DROP);
    addr_d  = new_req ? fetch_pc_d : addr_q;
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset; occupancy gates every read.
  always_ff @(posedge rclk) begin
    if (enq) begin
      q_mem[wr_ptr_q].pc   <= fetch_pc_q;
      q_mem[wr_ptr_q].word <= imem_rdata;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign q_count    = count_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? q_mem[rd_ptr_q].word : 32'd0;
  assign inst_pc    = inst_valid ? q_mem[rd_ptr_q].pc   : 32'd0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed scenarios push expected {pc, word}
// pairs; monitors pop and compare on every decode handshake.
module tb_inst_fetch_unit;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        rclk, rst;
  logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [2:0]  q_count;

  logic        imem_req_w, imem_ack_w, inst_valid_w, ready_w;
  logic [31:0] imem_addr_w, imem_rdata_w, inst_w, inst_pc_w;
  logic [2:0]  q_count_w;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int wait_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  exp_t sbw[$];

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .rclk(rclk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .q_count(q_count)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_w (
    .rclk(rclk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .redirect(1'b0),
    .redirect_pc(32'd0), .inst_valid(inst_valid_w), .inst(inst_w),
    .inst_pc(inst_pc_w), .inst_ready(ready_w), .q_count(q_count_w)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Memory models: configurable wait states for the main DUT, zero-wait for the other.
  always @(posedge rclk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack     = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata   = imem_addr ^ KEY;
  assign imem_ack_w   = imem_req_w;
  assign imem_rdata_w = imem_addr_w ^ KEY;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = pc ^ KEY;
    sb.push_back(e);
  endtask

  task automatic push_exp_w(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = pc ^ KEY;
    sbw.push_back(e);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    redirect = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_req",     32'(imem_req),   32'd0);
    check("rst_addr",    imem_addr,       32'h0);
    check("rst_valid",   32'(inst_valid), 32'd0);
    check("rst_inst",    inst,            32'h0);
    check("rst_inst_pc", inst_pc,         32'h0);
    check("rst_qcount",  32'(q_count),    32'd0);
    check("rst_addr_w",  imem_addr_w,     32'hFFFF_FFF8);
    repeat (2) @(posedge rclk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every decode handshake pops one expected entry.
  always @(negedge rclk) begin
    if (!rst && inst_valid && inst_ready && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop act_pc=%h exp=none t=%0t", inst_pc, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", inst_pc, e.pc);
        check("pop_inst", inst, e.word);
      end
    end
  end

  always @(negedge rclk) begin
    if (!rst && inst_valid_w && ready_w) begin
      if (sbw.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop_w act_pc=%h exp=none t=%0t", inst_pc_w, $time);
      end else begin
        exp_t e;
        e = sbw.pop_front();
        check("pop_pc_w", inst_pc_w, e.pc);
        check("pop_inst_w", inst_w, e.word);
      end
    end
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0; ready_w = 1'b0;
    #1;

    // Zero-wait streaming at one instruction per cycle.
    mem_wait   = 0;
    inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) push_exp(32'(4 * i));
    tick();
    check("e1_req", 32'(imem_req), 32'd1);
    check("e1_addr", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_pc", inst_pc, 32'(4 * i));
      check("stream_qcount", 32'(q_count), 32'd1);
      check("stream_addr", imem_addr, 32'(4 * (i + 1)));
    end
    inst_ready = 1'b0;

    // Fill with decode stalled, then release a single entry.
    do_reset();
    tick();
    repeat (4) tick();
    check("full_qcount", 32'(q_count), 32'd4);
    check("full_req", 32'(imem_req), 32'd0);
    tick();
    check("park_qcount", 32'(q_count), 32'd4);
    check("park_req", 32'(imem_req), 32'd0);
    push_exp(32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("release_qcount", 32'(q_count), 32'd3);
    check("release_req", 32'(imem_req), 32'd1);
    check("release_addr", imem_addr, 32'h10);
    tick();
    check("refill_qcount", 32'(q_count), 32'd4);
    check("refill_req", 32'(imem_req), 32'd0);
    check("refill_head", inst_pc, 32'h4);

    // Reset while a request is outstanding with two entries queued.
    mem_wait = 1;
    do_reset();
    repeat (5) tick();
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_qcount", 32'(q_count), 32'd2);
    check("mid_addr", imem_addr, 32'h8);
    do_reset();

    // Redirect during a slow request: old request held, its data dropped.
    mem_wait   = 2;
    inst_ready = 1'b1;
    do_reset();
    push_exp(32'h0);
    push_exp(32'h200);
    repeat (7) tick();
    check("pre_drop_addr", imem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, 32'h8);
    check("drop_qcount", 32'(q_count), 32'd0);
    tick();
    check("drop_hold_addr", imem_addr, 32'h8);
    tick();
    check("drop_new_addr", imem_addr, 32'h200);
    check("drop_discard_qcount", 32'(q_count), 32'd0);
    repeat (3) tick();
    check("target_valid", 32'(inst_valid), 32'd1);
    check("target_pc", inst_pc, 32'h200);
    tick();
    inst_ready = 1'b0;

    // Redirect coinciding with ack and decode ready, two entries queued.
    mem_wait = 1;
    do_reset();
    repeat (6) tick();
    check("pre_flush_qcount", 32'(q_count), 32'd2);
    check("pre_flush_addr", imem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    inst_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    check("flush_qcount", 32'(q_count), 32'd0);
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_inst", inst, 32'h0);
    check("flush_inst_pc", inst_pc, 32'h0);
    check("flush_addr", imem_addr, 32'h100);
    check("flush_req", 32'(imem_req), 32'd1);
    push_exp(32'h100);
    repeat (2) tick();
    check("flush_target_pc", inst_pc, 32'h100);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // PC wrap from the top of the address space.
    do_reset();
    push_exp_w(32'hFFFF_FFF8);
    push_exp_w(32'hFFFF_FFFC);
    push_exp_w(32'h0000_0000);
    ready_w = 1'b1;
    tick();
    check("wrap_e1_addr", imem_addr_w, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc0", inst_pc_w, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc1", inst_pc_w, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc2", inst_pc_w, 32'h0000_0000);
    tick();
    ready_w = 1'b0;
    tick();

    check("sb_final", 32'(sb.size()), 32'd0);
    check("sbw_final", 32'(sbw.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
